// File: rtl/local_pattern_predictor.sv
// Pattern history table: 2^HIST_W two-bit saturating counters indexed by local history.
// Latency: prediction registered one cycle after pred_req; training takes effect at the update edge.
// Backpressure: none, one prediction and one update accepted every cycle.
module local_pattern_predictor #(
    parameter int          HIST_W   = 4,
    parameter logic [1:0]  CNT_INIT = 2'b01,
    parameter int          MISS_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_req,
    input  logic [HIST_W-1:0] his_in,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [HIST_W-1:0] upd_his,
    input  logic              upd_pred_taken,
    input  logic              real_br_taken,
    output logic [MISS_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << HIST_W;

    logic [1:0]        pht_q [ENTRIES];
    logic [1:0]        upd_cur;
    logic [1:0]        upd_cnt_d;
    logic [1:0]        eff_cnt;
    logic              pred_valid_q;
    logic              pred_taken_q;
    logic              pred_valid_d;
    logic              pred_taken_d;
    logic [MISS_W-1:0] miss_q;
    logic [MISS_W-1:0] miss_d;

    // Trained counter value for the resolving branch, saturating at 0 and 3.
    always_comb begin
        upd_cur   = pht_q[upd_his];
        upd_cnt_d = upd_cur;
        if (real_br_taken) begin
            if (upd_cur != 2'b11) begin
                upd_cnt_d = upd_cur + 2'b01;
            end
        end else begin
            if (upd_cur != 2'b00) begin
                upd_cnt_d = upd_cur - 2'b01;
            end
        end
    end

    // Prediction uses the post-update counter when training hits the same entry this cycle.
    always_comb begin
        eff_cnt      = pht_q[his_in];
        if (upd_valid && (upd_his == his_in)) begin
            eff_cnt = upd_cnt_d;
        end
        pred_valid_d = pred_req;
        pred_taken_d = pred_taken_q;
        if (pred_req) begin
            pred_taken_d = eff_cnt[1];
        end
    end

    // Misprediction count saturates at all-ones; independent of the table contents.
    always_comb begin
        miss_d = miss_q;
        if (upd_valid && (upd_pred_taken != real_br_taken) && (miss_q != {MISS_W{1'b1}})) begin
            miss_d = miss_q + {{(MISS_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter table: reset to CNT_INIT, otherwise write the trained entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CNT_INIT;
            end
        end else if (upd_valid) begin
            pht_q[upd_his] <= upd_cnt_d;
        end
    end

    // Registered prediction outputs and misprediction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            miss_q       <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            miss_q       <= miss_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign mispred_cnt = miss_q;

endmodule
